pipe_hold_ctrl: RTL
===================

# pipe_hold_ctrl

Sequential pipeline hold/flush controller that produces the `hold_flag` consumed by the pc, if_id and id_ex stages, and the redirect (`jump_flag`/`jump_addr`) consumed by the pc stage. It merges hold requests from ex, the bus (rib), clint and jtag. A small FSM stretches post-jump flushes to a configurable length and tracks jtag halt. It also keeps a saturating count of stalled cycles for performance debug.

## Interface
- `FLUSH_CYCLES`, default 1: cycles `hold_flag_o` stays at `Hold_Id` per taken jump; legal range 1..15.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset; **asynchronous, active-low**.
- `jump_flag_i`  in  1  ex requests redirect.
- `jump_addr_i`  in  32  redirect target.
- `hold_flag_ex_i`  in  1  ex multi-cycle op (div) in progress.
- `hold_flag_rib_i`  in  1  bus arbiter stalls core fetch.
- `hold_flag_clint_i`  in  1  interrupt entry/exit in progress.
- `jtag_halt_flag_i`  in  1  debugger halt request (level).
- `stall_cnt_clr_i`  in  1  synchronous clear of stall counter.
- `hold_flag_o`  out  3  `Hold_None`(0) / `Hold_Pc`(1) / `Hold_If`(2) / `Hold_Id`(3).
- `jump_flag_o`  out  1  redirect pc this cycle.
- `jump_addr_o`  out  32  redirect target.
- `halted_o`  out  1  FSM in HALT.
- `stall_cycles_o`  out  32  saturating count of cycles with `hold_flag_o != Hold_None`.

## Operation
- The FSM has three states: RUN, FLUSH and HALT. A 4-bit `flush_cnt` goes with it.
- `jump_flag_o = jump_flag_i` and `jump_addr_o = jump_addr_i`, both combinational in every state. When `jump_flag_i` = 0, `jump_addr_o` is `ZeroWord`.
- `hold_flag_o` is the numeric maximum of these contributions:
  - `Hold_Id` if `jump_flag_i`, `hold_flag_ex_i`, `hold_flag_clint_i` or `jtag_halt_flag_i` is asserted.
  - `Hold_Id` if the state is FLUSH or HALT.
  - `Hold_Pc` if `hold_flag_rib_i` is asserted.
  - `Hold_None` otherwise.
- RUN state:
  - If `jtag_halt_flag_i` is asserted, go to HALT. This has priority over a jump: the jump is still output this cycle, but no FLUSH is entered.
  - Else, if `jump_flag_i` is asserted and `FLUSH_CYCLES` > 1, go to FLUSH with `flush_cnt = FLUSH_CYCLES-1`.
  - Else, stay in RUN.
- FLUSH state:
  - `jtag_halt_flag_i` → HALT; `flush_cnt` is cleared.
  - Else `jump_flag_i` → reload `flush_cnt = FLUSH_CYCLES-1` and stay in FLUSH.
  - Else `flush_cnt` == 1 → RUN.
  - Else decrement `flush_cnt`.
- HALT state: stay in HALT while `jtag_halt_flag_i` is asserted; go to RUN when it drops. A jump during HALT is passed through but does not schedule a FLUSH.
- `halted_o` is 1 only in HALT.
- Stall counter, in priority order:
  - `stall_cnt_clr_i` → 0.
  - Else, if `hold_flag_o != Hold_None` and the counter is not 0xFFFF_FFFF → +1.
  - At 0xFFFF_FFFF the counter holds (saturates).

## Timing
- Reset (`rst` = 0, async): state = RUN, `flush_cnt` = 0, `stall_cycles_o` = 0, `halted_o` = 0.
  - While `rst` is low, `hold_flag_o` is forced to `Hold_Id`, `jump_flag_o` to 0 and `jump_addr_o` to `ZeroWord`.
- Reset release: the first edge with `rst` = 1 samples inputs normally.
- Assertion of `rst` mid-FLUSH or mid-HALT aborts immediately to RUN.
- Latency of combinational hold/jump: 0 cycles (input → output in the same cycle).
- A jump in RUN holds `hold_flag_o` at `Hold_Id` for exactly `FLUSH_CYCLES` consecutive cycles: the jump cycle plus `FLUSH_CYCLES-1` FLUSH cycles.
- `halted_o` rises one edge after `jtag_halt_flag_i` is sampled high. It falls one edge after `jtag_halt_flag_i` is sampled low.
- The stall counter updates on the edge that ends a held cycle, so `stall_cycles_o` lags `hold_flag_o` by 1 cycle.
- Simultaneous rib and ex requests: `Hold_Id` wins.
- Simultaneous `stall_cnt_clr_i` and a hold: the counter is 0 after the edge.

## Test plan
- Reset behaviour: drive `rst` = 0 asynchronously, mid-cycle.
  - → `hold_flag_o` = 3, `jump_flag_o` = 0 and `stall_cycles_o` = 0 immediately.
  - After release with no requests → `hold_flag_o` = 0.
- Jump flush stretching: `FLUSH_CYCLES` = 3, single-cycle `jump_flag_i`, `jump_addr_i` = 0x0000_0100.
  - → `jump_flag_o` = 1 with addr 0x100 in the same cycle.
  - → `hold_flag_o` = 3 for exactly 3 cycles, then 0.
  - → `stall_cycles_o` = 3.
- Back-to-back jumps: `FLUSH_CYCLES` = 3, second jump on the 2nd FLUSH cycle.
  - → `hold_flag_o` = 3 for 2 + 3 = 5 consecutive cycles total.
- Bus stall and priority: `hold_flag_rib_i` alone for 4 cycles → `hold_flag_o` = 1, counter +4.
  - Add `hold_flag_ex_i` → `hold_flag_o` = 3.
- jtag halt: assert `jtag_halt_flag_i` during FLUSH.
  - → `halted_o` = 1 on the next edge and `hold_flag_o` = 3 throughout.
  - Deassert → `halted_o` = 0 one edge later and `hold_flag_o` = 0 with no residual flush.
- Counter saturation and clear: preload the counter to 0xFFFF_FFFE via a long hold.
  - → after 2 more held cycles it reads 0xFFFF_FFFF and stays there.
  - `stall_cnt_clr_i` during a hold → 0.

Source files
------------

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges stall requests, stretches post-jump
// flushes, tracks debugger halt and keeps a saturating stalled-cycle count.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_rib_i,
  input  logic        hold_flag_clint_i,
  input  logic        jtag_halt_flag_i,
  input  logic        stall_cnt_clr_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        halted_o,
  output logic [31:0] stall_cycles_o
);

  // Hold encoding: 0 none, 1 pc, 2 if (never produced here), 3 id.
  localparam logic [2:0]  HOLD_NONE    = 3'd0;
  localparam logic [2:0]  HOLD_PC      = 3'd1;
  localparam logic [2:0]  HOLD_ID      = 3'd3;
  localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] ZERO_WORD    = 32'h0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [31:0] stall_cnt;

  // Redirect and hold are combinational; reset forces a safe hold with no redirect.
  always_comb begin
    hold_flag_o = HOLD_NONE;
    jump_flag_o = 1'b0;
    jump_addr_o = ZERO_WORD;
    if (!rst) begin
      hold_flag_o = HOLD_ID;
    end else begin
      jump_flag_o = jump_flag_i;
      if (jump_flag_i) jump_addr_o = jump_addr_i;
      if (jump_flag_i || hold_flag_ex_i || hold_flag_clint_i ||
          jtag_halt_flag_i || (state != ST_RUN)) begin
        hold_flag_o = HOLD_ID;
      end else if (hold_flag_rib_i) begin
        hold_flag_o = HOLD_PC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      flush_cnt <= 4'd0;
      halted_o  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          // Halt wins over a simultaneous jump; the jump still goes out.
          if (jtag_halt_flag_i) begin
            state    <= ST_HALT;
            halted_o <= 1'b1;
          end else if (jump_flag_i && (FLUSH_CYCLES > 1)) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_RELOAD;
          end
        end
        ST_FLUSH: begin
          if (jtag_halt_flag_i) begin
            state     <= ST_HALT;
            flush_cnt <= 4'd0;
            halted_o  <= 1'b1;
          end else if (jump_flag_i) begin
            flush_cnt <= FLUSH_RELOAD;
          end else if (flush_cnt == 4'd1) begin
            state     <= ST_RUN;
            flush_cnt <= 4'd0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        ST_HALT: begin
          if (!jtag_halt_flag_i) begin
            state    <= ST_RUN;
            halted_o <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_cnt <= 4'd0;
          halted_o  <= 1'b0;
        end
      endcase
    end
  end

  // Counts cycles that ended held; clear beats increment, all-ones saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if (stall_cnt_clr_i) begin
      stall_cnt <= 32'd0;
    end else if ((hold_flag_o != HOLD_NONE) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt;

endmodule
